niosballe_pio_arbiter: RTL and testbench



---
 rtl/niosballe_arb_pkg.sv | 13 +
 rtl/niosballe_arb_slot.sv | 37 +++
 rtl/niosballe_pio_arbiter.sv | 117 +++++++++++
 tb/tb_niosballe_pio_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/niosballe_arb_pkg.sv
// Shared types and constants for the ball-control PIO write arbiter.
package niosballe_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 2;
  localparam int PIO_W_DEF  = 9;

  localparam logic REQ_NIOS   = 1'b0;
  localparam logic REQ_ENGINE = 1'b1;

  typedef enum logic {IDLE, ISSUE} state_t;

endpackage

// File: rtl/niosballe_arb_slot.sv
// One-entry write holding register; waitrequest is simply the registered valid bit.
module niosballe_arb_slot
  import niosballe_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  input  logic              clear,
  output logic              valid,
  output logic [ADDR_W-1:0] slot_address,
  output logic [DATA_W-1:0] slot_writedata,
  output logic              waitrequest
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid          <= 1'b0;
      slot_address   <= '0;
      slot_writedata <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (write && !valid) begin
      valid          <= 1'b1;
      slot_address   <= address;
      slot_writedata <= writedata;
    end
  end

  // Clear only fires on a full slot and accept only on an empty one, so they never collide.
  assign waitrequest = valid;

endmodule

// File: rtl/niosballe_pio_arbiter.sv
// Two-requester arbiter in front of the 9-bit ball-control PIO, with a local shadow copy.
// Define NIOSBALLE_ARB_FIXED_PRIO_EN to give the ball-update engine absolute priority on ties.
module niosballe_pio_arbiter
  import niosballe_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIO_W  = PIO_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [DATA_W-1:0] req0_writedata,
  output logic              req0_waitrequest,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [DATA_W-1:0] req1_writedata,
  output logic              req1_waitrequest,
  output logic [ADDR_W-1:0] pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [DATA_W-1:0] pio_writedata,
  output logic              grant_id,
  output logic [PIO_W-1:0]  shadow_value
);

  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]             wr;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_in;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]             slot_vld;
  logic [NUM_REQ-1:0][ADDR_W-1:0] slot_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] slot_data;
  logic [NUM_REQ-1:0]             slot_wait;
  logic [NUM_REQ-1:0]             slot_clr;

  state_t state;
  logic   last_grant;
  logic   winner;
  logic   any_vld;

  assign wr      = {req1_write, req0_write};
  assign addr_in = {req1_address, req0_address};
  assign data_in = {req1_writedata, req0_writedata};
  assign req0_waitrequest = slot_wait[REQ_NIOS];
  assign req1_waitrequest = slot_wait[REQ_ENGINE];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    niosballe_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
      .clk            (clk),
      .reset_n        (reset_n),
      .write          (wr[i]),
      .address        (addr_in[i]),
      .writedata      (data_in[i]),
      .clear          (slot_clr[i]),
      .valid          (slot_vld[i]),
      .slot_address   (slot_addr[i]),
      .slot_writedata (slot_data[i]),
      .waitrequest    (slot_wait[i])
    );
  end

  always_comb begin
    any_vld = |slot_vld;
    winner  = slot_vld[REQ_ENGINE] ? REQ_ENGINE : REQ_NIOS;
    if (&slot_vld) begin
`ifdef NIOSBALLE_ARB_FIXED_PRIO_EN
      winner = REQ_ENGINE;
`else
      winner = ~last_grant;
`endif
    end
  end

  // The winner's slot empties on the same edge the strobe is loaded.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_clr
    assign slot_clr[i] = (state == IDLE) && any_vld && (winner == i[0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= '0;
      pio_writedata  <= '0;
      grant_id       <= REQ_NIOS;
      last_grant     <= REQ_ENGINE;
      shadow_value   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_vld) begin
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_address    <= slot_addr[winner];
            pio_writedata  <= slot_data[winner];
            grant_id       <= winner;
            last_grant     <= winner;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          // Only register 0 is the ball-control value; others pass through untracked.
          if (pio_address == '0) shadow_value <= pio_writedata[PIO_W-1:0];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_niosballe_pio_arbiter.sv
// Directed bench for niosballe_pio_arbiter: per-requester pending model checked every cycle plus literal pins.
module tb_niosballe_pio_arbiter;

`ifdef NIOSBALLE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_write = 1'b0, req1_write = 1'b0;
  logic [1:0]  req0_address = '0, req1_address = '0;
  logic [31:0] req0_writedata = '0, req1_writedata = '0;
  logic        req0_waitrequest, req1_waitrequest;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n;
  logic [31:0] pio_writedata;
  logic        grant_id;
  logic [8:0]  shadow_value;

  niosballe_pio_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_write(req0_write), .req0_address(req0_address),
    .req0_writedata(req0_writedata), .req0_waitrequest(req0_waitrequest),
    .req1_write(req1_write), .req1_address(req1_address),
    .req1_writedata(req1_writedata), .req1_waitrequest(req1_waitrequest),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .grant_id(grant_id), .shadow_value(shadow_value)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each requester has at most one pending write; a write takes the PIO for two cycles.
  bit          p_v[2];
  logic [1:0]  p_a[2];
  logic [31:0] p_d[2];
  bit          m_busy, m_gid, m_last;
  logic [1:0]  m_addr;
  logic [31:0] m_data;
  logic [8:0]  m_sh;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_v <= '{0, 0}; p_a <= '{0, 0}; p_d <= '{0, 0};
      m_busy <= 0; m_gid <= 0; m_last <= 1; m_addr <= 0; m_data <= 0; m_sh <= 0;
    end else begin : mdl
      bit full[2];
      bit w;
      full = p_v;
      if (m_busy) begin
        m_busy <= 0;
        if (m_addr == 0) m_sh <= m_data[8:0];
      end else if (p_v[0] || p_v[1]) begin
        if (p_v[0] && p_v[1]) w = FIXED ? 1'b1 : !m_last;
        else w = p_v[1];
        m_busy <= 1; m_gid <= w; m_last <= w;
        m_addr <= p_a[w]; m_data <= p_d[w];
        p_v[w] <= 0;
      end
      if (req0_write && !full[0]) begin p_v[0] <= 1; p_a[0] <= req0_address; p_d[0] <= req0_writedata; end
      if (req1_write && !full[1]) begin p_v[1] <= 1; p_a[1] <= req1_address; p_d[1] <= req1_writedata; end
    end
  end

  bit obs_g[$];
  int obs_c[$];

  always @(negedge clk) begin
    if (reset_n) begin
      chk("chipselect", pio_chipselect, m_busy);
      chk("write_n", pio_write_n, !m_busy);
      chk("pio_address", pio_address, m_addr);
      chk("pio_writedata", pio_writedata, m_data);
      chk("grant_id", grant_id, m_gid);
      chk("shadow", shadow_value, m_sh);
      chk("wait0", req0_waitrequest, p_v[0]);
      chk("wait1", req1_waitrequest, p_v[1]);
      if (pio_chipselect) begin obs_g.push_back(grant_id); obs_c.push_back(cyc); end
    end
  end

  int acc_cyc;

  task automatic do_reset();
    @(negedge clk); #1;
    req0_write = 0; req1_write = 0;
    reset_n = 0; #2; reset_n = 1;
  endtask

  task automatic wr(input bit r, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    if (r) begin req1_write = 1; req1_address = a; req1_writedata = d; end
    else   begin req0_write = 1; req0_address = a; req0_writedata = d; end
    @(negedge clk); #1;
    req0_write = 0; req1_write = 0;
    acc_cyc = cyc;
  endtask

  task automatic wr_both(input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk); #1;
    req0_write = 1; req0_address = 0; req0_writedata = d0;
    req1_write = 1; req1_address = 0; req1_writedata = d1;
    @(negedge clk); #1;
    req0_write = 0; req1_write = 0;
    acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base, n0, n1;
    bit ws0, ws1, seen;
    bit exp_seq[8];

    #12;
    chk("rst_chipselect", pio_chipselect, 0);
    chk("rst_write_n", pio_write_n, 1);
    chk("rst_wait0", req0_waitrequest, 0);
    chk("rst_shadow", shadow_value, 0);
    reset_n = 1;

    // single Nios write to the ball-control register
    base = obs_c.size();
    wr(0, 2'd0, 32'h0000_01A5);
    idle(3);
    chk("t1_strobes", obs_c.size() - base, 1);
    if (obs_c.size() > base) chk("t1_latency", obs_c[base] - acc_cyc, 1);
    chk("t1_pio_data", pio_writedata, 32'h1A5);
    chk("t1_shadow", shadow_value, 9'h1A5);
    chk("t1_grant", grant_id, 0);

    // simultaneous accept
    do_reset();
    base = obs_g.size();
    wr_both(32'h011, 32'h022);
    idle(5);
    chk("t2_strobes", obs_g.size() - base, 2);
    if (obs_g.size() >= base + 2) begin
      chk("t2_first", obs_g[base], FIXED ? 1 : 0);
      chk("t2_gap", obs_c[base+1] - obs_c[base], 2);
    end
    chk("t2_shadow", shadow_value, FIXED ? 9'h011 : 9'h022);

    // back-to-back streams of four writes each
    do_reset();
    base = obs_g.size();
    n0 = 0; n1 = 0; ws0 = 0; ws1 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (req0_write && !ws0) n0++;
      if (req1_write && !ws1) n1++;
      req0_write = (n0 < 4); req0_address = 0; req0_writedata = 32'h100 + n0;
      req1_write = (n1 < 4); req1_address = 0; req1_writedata = 32'h180 + n1;
      ws0 = req0_waitrequest; ws1 = req1_waitrequest;
    end
    req0_write = 0; req1_write = 0;
    chk("t3_strobes", obs_g.size() - base, 8);
    if (FIXED) exp_seq = '{1, 1, 1, 1, 0, 0, 0, 0};
    else       exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
    if (obs_g.size() >= base + 8) begin
      for (int k = 0; k < 8; k++) chk($sformatf("t3_order%0d", k), obs_g[base+k], exp_seq[k]);
      chk("t3_span", obs_c[base+7] - obs_c[base], 14);
    end
    chk("t3_shadow", shadow_value, FIXED ? 9'h103 : 9'h183);

    // non-shadow address
    do_reset();
    base = obs_g.size();
    wr(1, 2'd1, 32'h1FF);
    @(negedge clk);
    chk("t4_cs", pio_chipselect, 1);
    chk("t4_addr", pio_address, 1);
    idle(3);
    chk("t4_shadow", shadow_value, 0);
    chk("t4_grant", grant_id, 1);

    // reset during ISSUE with the other slot still pending
    do_reset();
    @(negedge clk); #1;
    req0_write = 1; req0_address = 0; req0_writedata = 32'h0AA;
    req1_write = 1; req1_address = 0; req1_writedata = 32'h055;
    @(negedge clk); #1;
    req0_write = 0; req1_write = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = pio_chipselect;
    end
    chk("t5_strobe_seen", seen, 1);
    #2 reset_n = 0;
    #1;
    chk("t5_cs", pio_chipselect, 0);
    chk("t5_write_n", pio_write_n, 1);
    chk("t5_wait0", req0_waitrequest, 0);
    chk("t5_wait1", req1_waitrequest, 0);
    chk("t5_shadow", shadow_value, 0);
    #1 reset_n = 1;
    base = obs_g.size();
    idle(6);
    chk("t5_no_stale", obs_g.size() - base, 0);

    // upper data bits truncated in the shadow
    wr(0, 2'd0, 32'h0000_0123);
    idle(3);
    chk("t6_pre", shadow_value, 9'h123);
    wr(0, 2'd0, 32'hFFFF_FE00);
    idle(3);
    chk("t6_shadow", shadow_value, 9'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
